// File: rtl/param_shift_pipeline_if.sv
// Bus bundle for param_shift_pipeline: shift controls, tail input, head/tap outputs.
// The recirc signal exists only when SHIFT_PIPELINE_RECIRC_EN is defined.
interface param_shift_pipeline_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5
) ();
   localparam int TAPW = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);

   logic             en;
   logic             clear;
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic [TAPW-1:0]  tap_sel;
`ifdef SHIFT_PIPELINE_RECIRC_EN
   logic             recirc;
`endif
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [WIDTH-1:0] tap_out;
   logic             tap_valid;
   logic [CNTW-1:0]  fill_count;
   logic             full;

   modport master (
`ifdef SHIFT_PIPELINE_RECIRC_EN
      output recirc,
`endif
      output en, clear, din, din_valid, tap_sel,
      input  dout, dout_valid, tap_out, tap_valid, fill_count, full
   );

   modport slave (
`ifdef SHIFT_PIPELINE_RECIRC_EN
      input  recirc,
`endif
      input  en, clear, din, din_valid, tap_sel,
      output dout, dout_valid, tap_out, tap_valid, fill_count, full
   );
endinterface

// File: rtl/param_shift_pipeline.sv
// WIDTH-bit, DEPTH-stage delay line with stall, sync clear, valid tracking and a tap mux.
// Define SHIFT_PIPELINE_RECIRC_EN to add the recirc (rotate) input.
module param_shift_pipeline #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5
) (
   input logic                  clock,
   input logic                  reset,
   param_shift_pipeline_if.slave bus
);
   localparam int TAPW = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int unsigned NSTG = DEPTH;

   logic [WIDTH-1:0] s [DEPTH];
   logic [DEPTH-1:0] v;
   logic [CNTW-1:0]  fill_q;

   logic [WIDTH-1:0] tail_d;
   logic             tail_v;
   logic [CNTW-1:0]  fill_d;

   // Tail source and next occupancy; a rotation neither adds nor removes valid words.
   always_comb begin
      tail_d = bus.din;
      tail_v = bus.din_valid;
      fill_d = fill_q;
`ifdef SHIFT_PIPELINE_RECIRC_EN
      if (bus.recirc) begin
         tail_d = s[0];
         tail_v = v[0];
      end else
`endif
      begin
         case ({bus.din_valid, v[0]})
            2'b10:   fill_d = fill_q + CNTW'(1);
            2'b01:   fill_d = fill_q - CNTW'(1);
            default: fill_d = fill_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NSTG; i++) s[i] <= '0;
         v      <= '0;
         fill_q <= '0;
      end else if (bus.clear) begin
         for (int unsigned i = 0; i < NSTG; i++) s[i] <= '0;
         v      <= '0;
         fill_q <= '0;
      end else if (bus.en) begin
         for (int unsigned i = 0; i < NSTG - 1; i++) s[i] <= s[i+1];
         s[DEPTH-1] <= tail_d;
         v          <= {tail_v, v[DEPTH-1:1]};
         fill_q     <= fill_d;
      end
   end

   // Out-of-range selects (non-power-of-two DEPTH) fall through to zero.
   always_comb begin
      bus.tap_out   = '0;
      bus.tap_valid = 1'b0;
      for (int unsigned i = 0; i < NSTG; i++) begin
         if (bus.tap_sel == TAPW'(i)) begin
            bus.tap_out   = s[i];
            bus.tap_valid = v[i];
         end
      end
   end

   assign bus.dout       = s[0];
   assign bus.dout_valid = v[0];
   assign bus.fill_count = fill_q;
   assign bus.full       = (fill_q == CNTW'(DEPTH));
endmodule

// File: doc/param_shift_pipeline.md
Name: param_shift_pipeline

Overview:
- Parametrised successor to the team's fixed 8-bit, 5-stage shift register.
- A WIDTH-bit, DEPTH-stage word delay line with:
  - shift enable (stall)
  - synchronous clear
  - per-stage valid tracking
  - occupancy counter
  - run-time selectable tap output
- Sits in datapaths needing a programmable-length delay or alignment pipeline with bubble tracking.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 5, number of pipeline stages (>=2).
- TAPW, $clog2(DEPTH), width of tap_sel (derived, not overridden).
- CNTW, $clog2(DEPTH+1), width of fill_count (derived, not overridden).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  shift enable; when low, all state holds.
- clear  input  1  synchronous clear; priority over en.
- din  input  WIDTH  word entering tail stage S[DEPTH-1].
- din_valid  input  1  valid flag accompanying din.
- tap_sel  input  TAPW  selects stage S[tap_sel] for tap_out.
- dout  output  WIDTH  head stage S[0].
- dout_valid  output  1  valid flag of S[0].
- tap_out  output  WIDTH  data of selected stage.
- tap_valid  output  1  valid flag of selected stage.
- fill_count  output  CNTW  number of stages holding valid words (0..DEPTH).
- full  output  1  high when fill_count == DEPTH.

Behaviour:
- State:
  - data stages S[0..DEPTH-1], WIDTH bits each;
  - valid bits V[0..DEPTH-1];
  - fill_count register.
- reset high (async, any time, including mid-shift): all S, V and fill_count go to 0.
  - Resulting outputs: dout=0, dout_valid=0, tap_out=0, tap_valid=0, fill_count=0, full=0.
  - Remains so while reset is held.
- Per rising edge, priority order: clear, then en, then hold.
  - clear=1: S, V and fill_count go to 0 on that edge; en and din are ignored.
  - en=1, clear=0:
    - S[i] <= S[i+1] and V[i] <= V[i+1] for i in 0..DEPTH-2;
    - S[DEPTH-1] <= din, V[DEPTH-1] <= din_valid.
    - Old S[0] and V[0] are discarded.
  - en=0, clear=0: all state holds.
- Invalid words (din_valid=0) are still shifted in.
  - The word is stored as given, not zeroed; only V marks it as a bubble.
- Latency: a word presented with en=1 appears on dout after exactly DEPTH enabled edges.
  - Cycles with en=0 do not count towards latency.
- fill_count:
  - On an enabled edge: fill_count <= fill_count + din_valid - V[0].
  - Simultaneous entry and exit leaves the count unchanged.
  - Never exceeds DEPTH and never underflows.
  - Must always equal the popcount of V (verification invariant).
- full: combinational compare of fill_count against DEPTH.
  - While full, a shift with din_valid=1 is legal: the head word exits and the count stays at DEPTH.
  - No back-pressure is produced.
- Tap:
  - tap_out/tap_valid are combinational muxes of S[tap_sel]/V[tap_sel].
  - tap_sel >= DEPTH (non-power-of-two DEPTH) gives tap_out=0 and tap_valid=0.
- dout and dout_valid are direct register outputs with no combinational path from inputs.

Optional Feature:
- Macro: SHIFT_PIPELINE_RECIRC_EN.
- Defined:
  - Adds input port recirc (1 bit).
  - On an enabled, non-cleared edge with recirc=1, the tail loads S[0] and V[0] instead of din and din_valid, rotating the pipeline.
  - fill_count is unchanged on that edge.
  - clear and reset still take priority.
- Undefined:
  - The port is absent.
  - The tail always loads din/din_valid.

Test Plan (WIDTH=8, DEPTH=5):
- Reset: assert reset mid-stream with fill_count=3 -> all outputs 0 immediately, before the next clock edge; fill_count=0 after release.
- Fill and latency: en=1, push 0x11..0x55 valid -> dout=0x11 with dout_valid=1 after the 5th edge; fill_count=5; full=1.
- Stall and bubbles:
  - Push 0xA1 valid, 0xB2 invalid, then en=0 for 3 cycles -> outputs frozen during the stall.
  - 0xA1 reaches dout after 5 enabled edges.
  - fill_count counts only 0xA1.
- Full with simultaneous in/out: with full=1, push 0x66 valid -> 0x11 exits, dout=0x22, fill_count stays 5.
- Clear vs en: clear=1 and en=1 on the same edge with din=0x77 valid -> all V=0, fill_count=0, 0x77 not captured.
- Tap: contents 0x11..0x55, tap_sel=3 -> tap_out=0x44, tap_valid=1; tap_sel=6 -> tap_out=0x00, tap_valid=0.
- Recirculate (macro defined): full pipe, recirc=1 for 5 edges -> original order restored, fill_count=5 throughout.
